// File: rtl/word_context_product_seq.sv
// Sequential word/context dot product with LANES multipliers per cycle.
// Saturating Q-format result plus captured gradient vectors.
module word_context_product_seq #(
    parameter int DIM   = 3,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIM*WIDTH-1:0]   word_embv,
    input  logic [DIM*WIDTH-1:0]   context_embv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       y,
    output logic                   y_sat,
    output logic [DIM*WIDTH-1:0]   y_dword_vec,
    output logic [DIM*WIDTH-1:0]   y_dcontext_vec
);

    localparam int ACC_W = 2 * WIDTH + $clog2(DIM);
    localparam int IDX_W = $clog2(DIM) + 1;
    localparam int VEC_W = DIM * WIDTH;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - LANES);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN =
        {{(ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state_q;
    state_t state_nx;

    logic [VEC_W-1:0]        word_q;
    logic [VEC_W-1:0]        ctx_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_nx;
    logic signed [ACC_W-1:0] lane_sum;
    logic signed [ACC_W-1:0] res;
    logic [IDX_W-1:0]        idx_q;
    logic [WIDTH-1:0]        y_q;
    logic                    y_sat_q;
    logic [WIDTH-1:0]        y_nx;
    logic                    sat_nx;
    logic                    accept;
    logic                    last;

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == DONE);
    assign accept         = in_valid && in_ready;
    assign last           = (idx_q == LAST_IDX);
    assign y              = y_q;
    assign y_sat          = y_sat_q;
    assign y_dword_vec    = ctx_q;
    assign y_dcontext_vec = word_q;

    // Sum of this cycle's LANES products, sign-extended to the accumulator width
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + ACC_W'(
                $signed(word_q[(int'(idx_q) + l) * WIDTH +: WIDTH]) *
                $signed(ctx_q[(int'(idx_q) + l) * WIDTH +: WIDTH]));
        end
    end

    // Final scaling by FRAC (floor) and clipping into the WIDTH-bit range
    always_comb begin
        acc_nx = acc_q + lane_sum;
        res    = acc_nx >>> FRAC;
        y_nx   = res[WIDTH-1:0];
        sat_nx = 1'b0;
        if (res > Y_MAX) begin
            y_nx   = Y_MAX[WIDTH-1:0];
            sat_nx = 1'b1;
        end else if (res < Y_MIN) begin
            y_nx   = Y_MIN[WIDTH-1:0];
            sat_nx = 1'b1;
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state logic: accept -> MAC for DIM/LANES cycles -> hold result
    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            IDLE: if (accept) state_nx = MAC;
            MAC:  if (last) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, multiply-accumulate and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            ctx_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            y_sat_q <= 1'b0;
        end else if (accept) begin
            word_q <= word_embv;
            ctx_q  <= context_embv;
            acc_q  <= '0;
            idx_q  <= '0;
        end else if (state_q == MAC) begin
            acc_q <= acc_nx;
            idx_q <= idx_q + IDX_STEP;
            if (last) begin
                y_q     <= y_nx;
                y_sat_q <= sat_nx;
            end
        end
    end

endmodule

// File: tb/tb_word_context_product_seq.sv
// Scoreboard bench for word_context_product_seq: directed cases on a
// DIM=3/LANES=1 instance, randomized jobs on a DIM=8/LANES=4 instance.
module tb_word_context_product_seq;

    typedef struct {
        logic [15:0]  y;
        logic         sat;
        logic [127:0] w;
        logic [127:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sat;
    logic [47:0]  a_word, a_ctx, a_dw, a_dc;
    logic [15:0]  a_y;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sat;
    logic [127:0] b_word, b_ctx, b_dw, b_dc;
    logic [15:0]  b_y;

    exp_t qa[$];
    exp_t qb[$];
    int errors = 0;
    int checks = 0;

    word_context_product_seq #(
        .DIM(3), .WIDTH(16), .FRAC(8), .LANES(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .word_embv(a_word), .context_embv(a_ctx),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .y(a_y), .y_sat(a_sat),
        .y_dword_vec(a_dw), .y_dcontext_vec(a_dc)
    );

    word_context_product_seq #(
        .DIM(8), .WIDTH(16), .FRAC(8), .LANES(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .word_embv(b_word), .context_embv(b_ctx),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .y(b_y), .y_sat(b_sat),
        .y_dword_vec(b_dw), .y_dcontext_vec(b_dc)
    );

    // Reference: exact integer dot product, floor-divide by 256, clamp.
    function automatic exp_t model(input logic [127:0] w,
                                   input logic [127:0] c,
                                   input int dim);
        exp_t e;
        longint s;
        longint r;
        s = 0;
        for (int i = 0; i < dim; i++) begin
            s += longint'($signed(w[i*16 +: 16])) *
                 longint'($signed(c[i*16 +: 16]));
        end
        r = s >>> 8;
        if (r > 32767) begin
            e.y = 16'h7FFF;
            e.sat = 1'b1;
        end else if (r < -32768) begin
            e.y = 16'h8000;
            e.sat = 1'b1;
        end else begin
            e.y = r[15:0];
            e.sat = 1'b0;
        end
        e.w = w;
        e.c = c;
        return e;
    endfunction

    task automatic check(input string name,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] rand_elem();
        logic [15:0] v;
        case ($urandom % 4)
            0: v = 16'($urandom);
            1: v = 16'($urandom_range(0, 511)) - 16'd256;
            2: v = ($urandom % 2) ? 16'h7FFF : 16'h8000;
            default: v = 16'($urandom_range(0, 63));
        endcase
        return v;
    endfunction

    function automatic logic [127:0] rand_vec();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = rand_elem();
        return v;
    endfunction

    // Monitor A: compare each handed-off result with the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL a_unexpected got=%0h exp=none", a_y);
            end else begin
                e = qa.pop_front();
                check("a_y", 128'(a_y), 128'(e.y));
                check("a_sat", 128'(a_sat), 128'(e.sat));
                check("a_dword", 128'(a_dw), e.c);
                check("a_dcontext", 128'(a_dc), e.w);
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL b_unexpected got=%0h exp=none", b_y);
            end else begin
                e = qb.pop_front();
                check("b_y", 128'(b_y), 128'(e.y));
                check("b_sat", 128'(b_sat), 128'(e.sat));
                check("b_dword", b_dw, e.c);
                check("b_dcontext", b_dc, e.w);
            end
        end
    end

    task automatic wait_out_a(output int lat);
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (a_out_valid) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic send_a(input logic [47:0] w, input logic [47:0] c);
        int n;
        int lat;
        n = 0;
        while (!a_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_ready_wait", 128'(a_in_ready), 128'(1));
        a_word = w;
        a_ctx = c;
        a_in_valid = 1'b1;
        qa.push_back(model(128'(w), 128'(c), 3));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        wait_out_a(lat);
        check("a_latency", 128'(lat), 128'(3));
    endtask

    task automatic drain_a();
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (qa.size() == 0 && a_in_ready) break;
        end
        check("a_drain", 128'(qa.size()), 128'(0));
    endtask

    initial begin
        logic [47:0] w;
        logic [47:0] c;
        logic [15:0] y1;
        logic [47:0] dw1;
        int lat;
        int seen;
        int n;

        a_in_valid = 0; a_word = '0; a_ctx = '0; a_out_ready = 1;
        b_in_valid = 0; b_word = '0; b_ctx = '0; b_out_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_y", 128'(a_y), 128'(0));
        check("rst_sat", 128'(a_sat), 128'(0));
        check("rst_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_dword", 128'(a_dw), 128'(0));
        check("rst_dcontext", 128'(a_dc), 128'(0));
        check("rst_b_out_valid", 128'(b_out_valid), 128'(0));
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 128'(a_in_ready), 128'(1));
        @(posedge clk); #1;

        // Case 1: 0.5 - 2 + 6 = 4.5
        w = {16'h0300, 16'h0200, 16'h0100};
        c = {16'h0200, 16'hFF00, 16'h0080};
        send_a(w, c);
        check("t1_y", 128'(a_y), 128'(16'h0480));
        check("t1_sat", 128'(a_sat), 128'(0));
        check("t1_dword", 128'(a_dw), 128'(c));
        check("t1_dcontext", 128'(a_dc), 128'(w));
        drain_a();

        // Case 2: positive and negative saturation
        w = {3{16'h7F00}};
        send_a(w, w);
        check("t2_y_pos", 128'(a_y), 128'(16'h7FFF));
        check("t2_sat_pos", 128'(a_sat), 128'(1));
        drain_a();
        send_a({3{16'h8100}}, w);
        check("t2_y_neg", 128'(a_y), 128'(16'h8000));
        check("t2_sat_neg", 128'(a_sat), 128'(1));
        drain_a();

        // Case 3: floor of a tiny negative value
        send_a({16'h0, 16'h0, 16'h0001}, {16'h0, 16'h0, 16'hFF80});
        check("t3_y", 128'(a_y), 128'(16'hFFFF));
        check("t3_sat", 128'(a_sat), 128'(0));
        drain_a();

        // Case 4: backpressure with a new job waiting on the input
        a_out_ready = 1'b0;
        send_a({16'h0040, 16'hFFC0, 16'h0123}, {16'h0100, 16'h0200, 16'hFE00});
        y1 = a_y;
        dw1 = a_dw;
        w = {16'h0011, 16'h0500, 16'hF800};
        c = {16'h0300, 16'hFFF0, 16'h0040};
        a_word = w;
        a_ctx = c;
        a_in_valid = 1'b1;
        qa.push_back(model(128'(w), 128'(c), 3));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("t4_in_ready_busy", 128'(a_in_ready), 128'(0));
            check("t4_out_valid_hold", 128'(a_out_valid), 128'(1));
            check("t4_y_stable", 128'(a_y), 128'(y1));
            check("t4_vec_stable", 128'(a_dw), 128'(dw1));
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_out_valid_clear", 128'(a_out_valid), 128'(0));
        check("t4_idle_gap", 128'(a_in_ready), 128'(1));
        @(posedge clk); #1;
        check("t4_second_accept", 128'(a_in_ready), 128'(0));
        a_in_valid = 1'b0;
        wait_out_a(lat);
        check("t4_latency", 128'(lat), 128'(3));
        drain_a();

        // Case 5: reset during MAC drops the job
        check("t5_ready", 128'(a_in_ready), 128'(1));
        a_word = {16'h0100, 16'h0100, 16'h0100};
        a_ctx = {16'h0100, 16'h0100, 16'h0100};
        a_in_valid = 1'b1;
        qa.push_back(model(128'(a_word), 128'(a_ctx), 3));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        void'(qa.pop_back());
        #1;
        check("t5_out_valid", 128'(a_out_valid), 128'(0));
        check("t5_y", 128'(a_y), 128'(0));
        check("t5_sat", 128'(a_sat), 128'(0));
        check("t5_dword", 128'(a_dw), 128'(0));
        check("t5_dcontext", 128'(a_dc), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("t5_in_ready", 128'(a_in_ready), 128'(1));
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (a_out_valid) seen++;
        end
        check("t5_no_result", 128'(seen), 128'(0));
        send_a({16'hFF00, 16'h0280, 16'h0100}, {16'h0100, 16'h0100, 16'h0300});
        drain_a();

        // Case 6: DIM=8 LANES=4, randomized jobs and backpressure
        for (int j = 0; j < 1000; j++) begin
            n = 0;
            b_in_valid = 1'b0;
            while (!b_in_ready && n < 50) begin
                b_out_ready = 1'($urandom % 2);
                @(posedge clk); #1;
                n++;
            end
            check("b_ready_wait", 128'(b_in_ready), 128'(1));
            b_word = rand_vec();
            b_ctx = rand_vec();
            b_in_valid = 1'b1;
            qb.push_back(model(b_word, b_ctx, 8));
            @(posedge clk); #1;
            lat = -1;
            for (int e = 1; e <= 20; e++) begin
                b_in_valid = 1'($urandom % 2);
                b_word = rand_vec();
                b_ctx = rand_vec();
                b_out_ready = 1'($urandom % 2);
                @(posedge clk); #1;
                if (b_out_valid) begin
                    lat = e;
                    break;
                end
            end
            b_in_valid = 1'b0;
            check("b_latency", 128'(lat), 128'(2));
        end
        b_out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (qb.size() == 0) break;
        end
        check("b_drain", 128'(qb.size()), 128'(0));
        check("a_final_empty", 128'(qa.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
